param_action_crossbar: RTL and testbench

PARAM_ACTION_CROSSBAR -- requirements
Module: param_action_crossbar

---
 rtl/param_action_crossbar_pkg.sv | 27 ++
 rtl/param_action_crossbar_operand_sel.sv | 56 +++++
 rtl/param_action_crossbar.sv | 143 ++++++++++++++
 tb/tb_param_action_crossbar.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_action_crossbar_pkg.sv
// rtl/param_action_crossbar_pkg.sv - shared class codes, action slot layout and default widths
package param_action_crossbar_pkg;

    typedef enum logic [1:0] {
        CLS_6B  = 2'b00,
        CLS_4B  = 2'b01,
        CLS_2B  = 2'b10,
        CLS_INV = 2'b11
    } cont_class_e;

    localparam int OP_LSB       = 21;
    localparam int OP_W         = 4;
    localparam int SRC1_LSB     = 16;
    localparam int SRC2_LSB     = 11;
    localparam int SRC_W        = 5;
    localparam int IMM_LSB      = 0;
    localparam int IMM_W        = 16;
    localparam int IMM_MODE_BIT = 3;

    localparam int DEF_N_CONT     = 8;
    localparam int DEF_W6B        = 48;
    localparam int DEF_W4B        = 32;
    localparam int DEF_W2B        = 16;
    localparam int DEF_ACT_LEN    = 25;
    localparam int DEF_REMAIN_LEN = 356;

endpackage

// File: rtl/param_action_crossbar_operand_sel.sv
// rtl/param_action_crossbar_operand_sel.sv - picks one PHV container by index and fits it to an ALU width
module crossbar_operand_sel
    import param_action_crossbar_pkg::*;
#(
    parameter int N_CONT = DEF_N_CONT,
    parameter int W6B    = DEF_W6B,
    parameter int W4B    = DEF_W4B,
    parameter int W2B    = DEF_W2B,
    parameter int W_OUT  = DEF_W6B
) (
    input  logic [N_CONT*(W6B+W4B+W2B)-1:0] cont,
    input  logic [SRC_W-1:0]                sel,
    input  logic                            en,
    output logic [W_OUT-1:0]                data,
    output logic                            bad
);

    cont_class_e            cls;
    logic [2:0]             idx;
    logic [2:0]             sidx;
    logic                   idx_ok;
    logic [W6B-1:0]         v6;
    logic [W4B-1:0]         v4;
    logic [W2B-1:0]         v2;
    logic [W6B+W_OUT-1:0]   p6;
    logic [W4B+W_OUT-1:0]   p4;
    logic [W2B+W_OUT-1:0]   p2;

    assign cls    = cont_class_e'(sel[4:3]);
    assign idx    = sel[2:0];
    assign idx_ok = (cls != CLS_INV) && (32'(idx) < N_CONT);
    // Out-of-range indices are steered to 0 so the part-selects never leave the bus.
    assign sidx   = idx_ok ? idx : 3'd0;

    assign v6 = cont[N_CONT*(W4B+W2B) + sidx*W6B +: W6B];
    assign v4 = cont[N_CONT*W2B + sidx*W4B +: W4B];
    assign v2 = cont[sidx*W2B +: W2B];

    assign p6 = {{W_OUT{1'b0}}, v6};
    assign p4 = {{W_OUT{1'b0}}, v4};
    assign p2 = {{W_OUT{1'b0}}, v2};

    always_comb begin
        data = '0;
        if (en && idx_ok) begin
            case (cls)
                CLS_6B:  data = p6[W_OUT-1:0];
                CLS_4B:  data = p4[W_OUT-1:0];
                default: data = p2[W_OUT-1:0];
            endcase
        end
    end

    assign bad = en && !idx_ok;

endmodule

// File: rtl/param_action_crossbar.sv
// rtl/param_action_crossbar.sv - joins a PHV with its action word and registers per-ALU operands
module param_action_crossbar
    import param_action_crossbar_pkg::*;
#(
    parameter int N_CONT     = DEF_N_CONT,
    parameter int W6B        = DEF_W6B,
    parameter int W4B        = DEF_W4B,
    parameter int W2B        = DEF_W2B,
    parameter int ACT_LEN    = DEF_ACT_LEN,
    parameter int REMAIN_LEN = DEF_REMAIN_LEN,
    localparam int PHV_LEN   = N_CONT*(W6B+W4B+W2B)+REMAIN_LEN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PHV_LEN-1:0]          phv_in,
    input  logic                        phv_in_valid,
    output logic                        phv_in_ready,
    input  logic [3*N_CONT*ACT_LEN-1:0] action_in,
    input  logic                        action_in_valid,
    output logic                        action_in_ready,
    output logic                        alu_in_valid,
    input  logic                        alu_in_ready,
    output logic [N_CONT*W6B-1:0]       alu_in_6B_1,
    output logic [N_CONT*W6B-1:0]       alu_in_6B_2,
    output logic [N_CONT*W4B-1:0]       alu_in_4B_1,
    output logic [N_CONT*W4B-1:0]       alu_in_4B_2,
    output logic [N_CONT*W2B-1:0]       alu_in_2B_1,
    output logic [N_CONT*W2B-1:0]       alu_in_2B_2,
    output logic [3*N_CONT*ACT_LEN-1:0] action_out,
    output logic [REMAIN_LEN-1:0]       phv_remain_data,
    output logic                        bad_idx
);

    localparam int CONT_LEN = N_CONT*(W6B+W4B+W2B);
    localparam int ACTW     = 3*N_CONT*ACT_LEN;

    logic [PHV_LEN-1:0]    phv_slot;
    logic                  phv_full;
    logic [ACTW-1:0]       act_slot;
    logic                  act_full;
    logic                  out_valid;
    logic                  fire;
    logic [CONT_LEN-1:0]   cont;
    logic [CONT_LEN-1:0]   op1_next, op2_next, op1_q, op2_q;
    logic [ACTW-1:0]       act_q;
    logic [REMAIN_LEN-1:0] remain_q;
    logic [3*N_CONT-1:0]   bad_vec;
    logic                  bad_q;

    assign cont            = phv_slot[PHV_LEN-1:REMAIN_LEN];
    assign fire            = phv_full && act_full && (!out_valid || alu_in_ready);
    assign phv_in_ready    = rst_n && (!phv_full || fire);
    assign action_in_ready = rst_n && (!act_full || fire);

    // Operand buses share the PHV container layout: 6B on top, then 4B, then 2B.
    for (genvar c = 0; c < 3; c++) begin : g_cls
        localparam int W    = (c == 0) ? W6B : (c == 1) ? W4B : W2B;
        localparam int BASE = (c == 0) ? N_CONT*(W4B+W2B) : (c == 1) ? N_CONT*W2B : 0;
        for (genvar i = 0; i < N_CONT; i++) begin : g_alu
            localparam int AOFF = ((2-c)*N_CONT + i)*ACT_LEN;
            localparam logic [SRC_W-1:0] OWN = SRC_W'(c*8 + i);
            logic [ACT_LEN-1:0]   slot;
            logic [OP_W-1:0]      op;
            logic [SRC_W-1:0]     sel1;
            logic                 en2;
            logic [IMM_W+W-1:0]   imm_pad;
            logic [W-1:0]         s1_data, s2_data;
            logic                 s1_bad, s2_bad;

            assign slot    = act_slot[AOFF +: ACT_LEN];
            assign op      = slot[OP_LSB +: OP_W];
            assign sel1    = (op == '0) ? OWN : slot[SRC1_LSB +: SRC_W];
            assign en2     = (op != '0) && !op[IMM_MODE_BIT];
            assign imm_pad = {{W{1'b0}}, slot[IMM_LSB +: IMM_W]};

            crossbar_operand_sel #(
                .N_CONT(N_CONT), .W6B(W6B), .W4B(W4B), .W2B(W2B), .W_OUT(W)
            ) u_sel1 (
                .cont(cont), .sel(sel1), .en(1'b1), .data(s1_data), .bad(s1_bad)
            );

            crossbar_operand_sel #(
                .N_CONT(N_CONT), .W6B(W6B), .W4B(W4B), .W2B(W2B), .W_OUT(W)
            ) u_sel2 (
                .cont(cont), .sel(slot[SRC2_LSB +: SRC_W]), .en(en2), .data(s2_data), .bad(s2_bad)
            );

            assign op1_next[BASE + i*W +: W] = s1_data;
            assign op2_next[BASE + i*W +: W] = op[IMM_MODE_BIT] ? imm_pad[W-1:0] : s2_data;
            assign bad_vec[c*N_CONT + i]     = s1_bad | s2_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_slot  <= '0;
            phv_full  <= 1'b0;
            act_slot  <= '0;
            act_full  <= 1'b0;
            out_valid <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            act_q     <= '0;
            remain_q  <= '0;
            bad_q     <= 1'b0;
        end else begin
            if (phv_in_valid && phv_in_ready) begin
                phv_slot <= phv_in;
                phv_full <= 1'b1;
            end else if (fire) begin
                phv_full <= 1'b0;
            end
            if (action_in_valid && action_in_ready) begin
                act_slot <= action_in;
                act_full <= 1'b1;
            end else if (fire) begin
                act_full <= 1'b0;
            end
            if (fire) begin
                out_valid <= 1'b1;
                op1_q     <= op1_next;
                op2_q     <= op2_next;
                act_q     <= act_slot;
                remain_q  <= phv_slot[REMAIN_LEN-1:0];
                bad_q     <= bad_q | (|bad_vec);
            end else if (alu_in_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign alu_in_valid    = out_valid;
    assign alu_in_6B_1     = op1_q[CONT_LEN-1 -: N_CONT*W6B];
    assign alu_in_6B_2     = op2_q[CONT_LEN-1 -: N_CONT*W6B];
    assign alu_in_4B_1     = op1_q[N_CONT*W2B +: N_CONT*W4B];
    assign alu_in_4B_2     = op2_q[N_CONT*W2B +: N_CONT*W4B];
    assign alu_in_2B_1     = op1_q[0 +: N_CONT*W2B];
    assign alu_in_2B_2     = op2_q[0 +: N_CONT*W2B];
    assign action_out      = act_q;
    assign phv_remain_data = remain_q;
    assign bad_idx         = bad_q;

endmodule

// File: tb/tb_param_action_crossbar.sv
// tb/tb_param_action_crossbar.sv - directed self-checking bench for param_action_crossbar
module tb_param_action_crossbar;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1123:0]  phv_in;
    logic           phv_in_valid;
    logic           phv_in_ready;
    logic [599:0]   action_in;
    logic           action_in_valid;
    logic           action_in_ready;
    logic           alu_in_valid;
    logic           alu_in_ready;
    logic [383:0]   alu_in_6B_1, alu_in_6B_2;
    logic [255:0]   alu_in_4B_1, alu_in_4B_2;
    logic [127:0]   alu_in_2B_1, alu_in_2B_2;
    logic [599:0]   action_out;
    logic [355:0]   phv_remain_data;
    logic           bad_idx;

    logic [1123:0]  phv;
    logic [599:0]   act;
    logic [383:0]   snap;
    int             cmps = 0;
    int             errs = 0;

    always #5 clk = ~clk;

    param_action_crossbar dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
        .action_in(action_in), .action_in_valid(action_in_valid), .action_in_ready(action_in_ready),
        .alu_in_valid(alu_in_valid), .alu_in_ready(alu_in_ready),
        .alu_in_6B_1(alu_in_6B_1), .alu_in_6B_2(alu_in_6B_2),
        .alu_in_4B_1(alu_in_4B_1), .alu_in_4B_2(alu_in_4B_2),
        .alu_in_2B_1(alu_in_2B_1), .alu_in_2B_2(alu_in_2B_2),
        .action_out(action_out), .phv_remain_data(phv_remain_data), .bad_idx(bad_idx)
    );

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cont(input int c, input int i, input logic [47:0] v);
        int w, off;
        w   = (c == 0) ? 48 : (c == 1) ? 32 : 16;
        off = 356 + ((c == 0) ? 384 : (c == 1) ? 128 : 0) + i*w;
        for (int b = 0; b < w; b++) phv[off+b] = v[b];
    endtask

    task automatic set_slot(input int c, input int i, input logic [24:0] s);
        int off;
        off = ((2-c)*8 + i)*25;
        for (int b = 0; b < 25; b++) act[off+b] = s[b];
    endtask

    task automatic send_pair();
        phv_in = phv; action_in = act;
        phv_in_valid = 1'b1; action_in_valid = 1'b1;
        step();
        phv_in_valid = 1'b0; action_in_valid = 1'b0;
        chk("latency_not_early", alu_in_valid, 1'b0);
        step();
    endtask

    initial begin
        rst_n = 1'b0; phv_in = '0; action_in = '0;
        phv_in_valid = 1'b0; action_in_valid = 1'b0; alu_in_ready = 1'b1;
        #12;
        chk("rst_phv_ready", phv_in_ready, 1'b0);
        chk("rst_act_ready", action_in_ready, 1'b0);
        chk("rst_valid", alu_in_valid, 1'b0);
        chk("rst_bad", bad_idx, 1'b0);
        chk("rst_op1", alu_in_6B_1, 384'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_phv_ready", phv_in_ready, 1'b1);
        chk("post_rst_act_ready", action_in_ready, 1'b1);

        // Register-register op between two 6B containers
        phv = '0; act = '0;
        set_cont(0, 7, 48'hfffffffffffe);
        set_cont(0, 6, 48'heeeeeeeeeeef);
        phv[63:0] = 64'h0123456789abcdef;
        set_slot(0, 7, {4'b0001, 5'd6, 5'd7, 11'd0});
        send_pair();
        chk("s1_valid", alu_in_valid, 1'b1);
        chk("s1_op1", alu_in_6B_1[7*48 +: 48], 48'heeeeeeeeeeef);
        chk("s1_op2", alu_in_6B_2[7*48 +: 48], 48'hfffffffffffe);
        chk("s1_pass_op1", alu_in_6B_1[6*48 +: 48], 48'heeeeeeeeeeef);
        chk("s1_pass_op2", alu_in_6B_2[6*48 +: 48], 48'h0);
        chk("s1_action", action_out, act);
        chk("s1_remain", phv_remain_data, 356'h0123456789abcdef);
        step();
        chk("s1_drained", alu_in_valid, 1'b0);

        // Immediate mode
        phv = '0; act = '0;
        set_cont(0, 6, 48'heeeeeeeeeeee);
        set_slot(0, 7, {4'b1010, 5'd6, 16'hffff});
        send_pair();
        chk("s2_op1", alu_in_6B_1[7*48 +: 48], 48'heeeeeeeeeeee);
        chk("s2_op2", alu_in_6B_2[7*48 +: 48], 48'h00000000ffff);
        step();

        // Pass-through
        phv = '0; act = '0;
        set_cont(0, 7, 48'hffffffffffff);
        send_pair();
        chk("s3_op1", alu_in_6B_1[7*48 +: 48], 48'hffffffffffff);
        chk("s3_op2", alu_in_6B_2[7*48 +: 48], 48'h0);
        chk("s3_bad", bad_idx, 1'b0);
        step();

        // PHV waits for a late action while the output side stalls
        alu_in_ready = 1'b0;
        phv = '0; act = '0;
        set_cont(0, 7, 48'h123456789abc);
        phv_in = phv; phv_in_valid = 1'b1;
        step();
        phv = '0;
        set_cont(0, 7, 48'h0fedcba98765);
        phv_in = phv;
        chk("s4_second_phv_blocked", phv_in_ready, 1'b0);
        step();
        step();
        chk("s4_still_blocked", phv_in_ready, 1'b0);
        chk("s4_no_output", alu_in_valid, 1'b0);
        action_in = act; action_in_valid = 1'b1;
        step();
        action_in_valid = 1'b0;
        chk("s4_ready_on_fire", phv_in_ready, 1'b1);
        step();
        phv_in_valid = 1'b0;
        chk("s4_valid", alu_in_valid, 1'b1);
        chk("s4_first_phv", alu_in_6B_1[7*48 +: 48], 48'h123456789abc);
        snap = alu_in_6B_1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s4_hold_valid", alu_in_valid, 1'b1);
            chk("s4_hold_data", alu_in_6B_1, snap);
        end
        alu_in_ready = 1'b1;
        step();
        chk("s4_consumed", alu_in_valid, 1'b0);
        action_in = '0; action_in_valid = 1'b1;
        step();
        action_in_valid = 1'b0;
        step();
        chk("s4_second_valid", alu_in_valid, 1'b1);
        chk("s4_second_phv", alu_in_6B_1[7*48 +: 48], 48'h0fedcba98765);
        step();

        // Invalid index and cross-width sources
        phv = '0; act = '0;
        set_cont(1, 0, 48'hdeadbeef);
        set_cont(0, 7, 48'h111122223333);
        set_cont(1, 1, 48'h55556666);
        set_cont(2, 2, 48'habcd);
        set_slot(1, 0, {4'b0001, 5'b11000, 5'b01000, 11'd0});
        set_slot(2, 0, {4'b0001, 5'b00111, 5'b01001, 11'd0});
        set_slot(0, 0, {4'b0001, 5'b10010, 5'b01001, 11'd0});
        send_pair();
        chk("s5_bad_op1", alu_in_4B_1[31:0], 32'h0);
        chk("s5_bad_op2", alu_in_4B_2[31:0], 32'hdeadbeef);
        chk("s5_bad_idx", bad_idx, 1'b1);
        chk("s5_trunc_op1", alu_in_2B_1[15:0], 16'h3333);
        chk("s5_trunc_op2", alu_in_2B_2[15:0], 16'h6666);
        chk("s5_zext_op1", alu_in_6B_1[47:0], 48'h00000000abcd);
        chk("s5_zext_op2", alu_in_6B_2[47:0], 48'h000055556666);
        step();

        // Back-to-back stream of 16 pairs
        act = '0; action_in = act;
        for (int t = 0; t <= 16; t++) begin
            if (t < 16) begin
                phv = '0;
                set_cont(0, 0, 48'(t + 1));
                phv_in = phv; phv_in_valid = 1'b1; action_in_valid = 1'b1;
            end else begin
                phv_in_valid = 1'b0; action_in_valid = 1'b0;
            end
            step();
            if (t >= 1) begin
                chk("s6_stream_valid", alu_in_valid, 1'b1);
                chk("s6_stream_data", alu_in_6B_1[47:0], 48'(t));
            end
        end
        step();
        chk("s6_stream_end", alu_in_valid, 1'b0);
        chk("s6_bad_sticky", bad_idx, 1'b1);

        // Reset pulse mid-stream
        for (int t = 0; t < 4; t++) begin
            phv = '0;
            set_cont(0, 0, 48'(t + 100));
            phv_in = phv; phv_in_valid = 1'b1; action_in_valid = 1'b1;
            step();
        end
        chk("s7_pre_rst_valid", alu_in_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("s7_rst_valid", alu_in_valid, 1'b0);
        chk("s7_rst_ready", phv_in_ready, 1'b0);
        chk("s7_rst_bad", bad_idx, 1'b0);
        chk("s7_rst_data", alu_in_6B_1, 384'h0);
        phv_in_valid = 1'b0; action_in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("s7_no_stale", alu_in_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
